// File: rtl/assoc_instruction_cache_pkg.sv
// Shared constants, miss-FSM state type and sizing helper for the set-associative instruction cache.
package assoc_instruction_cache_pkg;

  localparam int IC_WIDTH_DEFAULT = 6;
  localparam int IC_WAYS_DEFAULT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } miss_state_t;

  // A direct-mapped cache still needs a one-bit pointer so the vector is never zero-width.
  function automatic int ptr_width(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/assoc_instruction_cache_if.sv
// Fetch lookup, refill request and fill bus between the core, the cache and memory control.
interface assoc_instruction_cache_if;
  logic        read_ic_valid;
  logic [31:0] read_ic_addr;
  logic        read_ic_rdy;
  logic [31:0] read_ic_data;
  logic        read_ic_is_compressed;
  logic        miss_valid;
  logic [31:0] miss_addr;
  logic        miss_ack;
  logic        write_ic_rdy;
  logic [31:0] write_ic_addr;
  logic [31:0] write_ic_data;
  logic        write_ic_is_compressed;

  modport slave (
    input  read_ic_valid, read_ic_addr, miss_ack,
    input  write_ic_rdy, write_ic_addr, write_ic_data, write_ic_is_compressed,
    output read_ic_rdy, read_ic_data, read_ic_is_compressed, miss_valid, miss_addr
  );

  modport master (
    output read_ic_valid, read_ic_addr, miss_ack,
    output write_ic_rdy, write_ic_addr, write_ic_data, write_ic_is_compressed,
    input  read_ic_rdy, read_ic_data, read_ic_is_compressed, miss_valid, miss_addr
  );
endinterface

// File: rtl/assoc_instruction_cache_victim_select.sv
// Picks the way a fill lands in: matching tag first, then lowest invalid way, then round-robin.
module ic_victim_select #(
  parameter int WAYS  = 2,
  parameter int PTR_W = 1
) (
  input  logic [WAYS-1:0]  i_valid,
  input  logic [WAYS-1:0]  i_match,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [PTR_W-1:0] o_victim,
  output logic             o_advance
);

  always_comb begin
    o_victim  = i_ptr;
    o_advance = 1'b1;
    // Descending scans so the lowest-numbered candidate wins; a tag match overrides everything.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!i_valid[w]) begin
        o_victim  = PTR_W'(w);
        o_advance = 1'b0;
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (i_match[w]) begin
        o_victim  = PTR_W'(w);
        o_advance = 1'b0;
      end
    end
  end

endmodule

// File: rtl/assoc_instruction_cache.sv
// Set-associative instruction cache: zero-latency lookup, single outstanding refill, fill-anytime writes.
module assoc_instruction_cache
  import assoc_instruction_cache_pkg::*;
#(
  parameter int IC_WIDTH = IC_WIDTH_DEFAULT,
  parameter int IC_WAYS  = IC_WAYS_DEFAULT
) (
  input logic                      clk_in,
  input logic                      rst_in,
  input logic                      rdy_in,
  input logic                      flush_in,
  assoc_instruction_cache_if.slave bus
);

  localparam int SETS  = 1 << IC_WIDTH;
  localparam int TAG_W = 31 - IC_WIDTH;
  localparam int PTR_W = ptr_width(IC_WAYS);

  logic [IC_WAYS-1:0] r_valid [SETS];
  logic [TAG_W-1:0]   r_tag   [SETS][IC_WAYS];
  logic [31:0]        r_data  [SETS][IC_WAYS];
  logic               r_cmp   [SETS][IC_WAYS];
  logic [PTR_W-1:0]   r_ptr   [SETS];
  miss_state_t        r_state;
  logic               r_miss_valid;
  logic [31:0]        r_miss_addr;

  logic [IC_WIDTH-1:0] w_rd_idx;
  logic [IC_WIDTH-1:0] w_wr_idx;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [TAG_W-1:0]    w_wr_tag;
  logic                w_hit;
  logic [31:0]         w_hit_data;
  logic                w_hit_cmp;
  logic [IC_WAYS-1:0]  w_wr_match;
  logic [PTR_W-1:0]    w_victim;
  logic                w_advance;
  logic                w_fill;

  assign w_rd_idx = bus.read_ic_addr[IC_WIDTH:1];
  assign w_rd_tag = bus.read_ic_addr[31:IC_WIDTH+1];
  assign w_wr_idx = bus.write_ic_addr[IC_WIDTH:1];
  assign w_wr_tag = bus.write_ic_addr[31:IC_WIDTH+1];

  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    w_hit_cmp  = 1'b0;
    for (int w = 0; w < IC_WAYS; w++) begin
      if (r_valid[w_rd_idx][w] && (r_tag[w_rd_idx][w] == w_rd_tag)) begin
        w_hit      = 1'b1;
        w_hit_data = r_data[w_rd_idx][w];
        w_hit_cmp  = r_cmp[w_rd_idx][w];
      end
    end
  end

  assign bus.read_ic_rdy           = bus.read_ic_valid & w_hit;
  assign bus.read_ic_data          = bus.read_ic_rdy ? w_hit_data : '0;
  assign bus.read_ic_is_compressed = bus.read_ic_rdy & w_hit_cmp;
  assign bus.miss_valid            = r_miss_valid;
  assign bus.miss_addr             = r_miss_addr;

  always_comb begin
    w_wr_match = '0;
    for (int w = 0; w < IC_WAYS; w++) begin
      w_wr_match[w] = r_valid[w_wr_idx][w] && (r_tag[w_wr_idx][w] == w_wr_tag);
    end
  end

  ic_victim_select #(
    .WAYS  (IC_WAYS),
    .PTR_W (PTR_W)
  ) u_victim_select (
    .i_valid   (r_valid[w_wr_idx]),
    .i_match   (w_wr_match),
    .i_ptr     (r_ptr[w_wr_idx]),
    .o_victim  (w_victim),
    .o_advance (w_advance)
  );

  // A flush in the same cycle drops the fill.
  assign w_fill = rdy_in & ~flush_in & bus.write_ic_rdy;

  always_ff @(posedge clk_in) begin
    if (rst_in || (rdy_in && flush_in)) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
      end
    end else if (w_fill) begin
      for (int w = 0; w < IC_WAYS; w++) begin
        if (PTR_W'(w) == w_victim) r_valid[w_wr_idx][w] <= 1'b1;
      end
      if (w_advance) begin
        r_ptr[w_wr_idx] <= (r_ptr[w_wr_idx] == PTR_W'(IC_WAYS - 1)) ? '0 : r_ptr[w_wr_idx] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_fill) begin
      for (int w = 0; w < IC_WAYS; w++) begin
        if (PTR_W'(w) == w_victim) begin
          r_tag[w_wr_idx][w]  <= w_wr_tag;
          r_data[w_wr_idx][w] <= bus.write_ic_data;
          r_cmp[w_wr_idx][w]  <= bus.write_ic_is_compressed;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state      <= ST_IDLE;
      r_miss_valid <= 1'b0;
      r_miss_addr  <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        r_state      <= ST_IDLE;
        r_miss_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: if (bus.read_ic_valid && !bus.read_ic_rdy) begin
            r_state      <= ST_REQ;
            r_miss_valid <= 1'b1;
            r_miss_addr  <= {bus.read_ic_addr[31:1], 1'b0};
          end
          ST_REQ: if (bus.miss_ack) begin
            r_state      <= ST_WAIT;
            r_miss_valid <= 1'b0;
          end
          ST_WAIT: if (bus.write_ic_rdy && (bus.write_ic_addr[31:1] == r_miss_addr[31:1])) begin
            r_state <= ST_IDLE;
          end
          default: begin
            r_state      <= ST_IDLE;
            r_miss_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
